// File: rtl/arm_core_pkg.sv
// Core-wide ARM register constants shared by the register file and its scoreboard.
package arm_core_pkg;

   localparam int REG_SP = 13;
   localparam int REG_LR = 14;
   localparam int REG_PC = 15;

   localparam int REG_AW = 4;

   typedef logic [REG_AW-1:0] reg_addr_t;

endpackage

// File: rtl/arm_rf_scoreboard.sv
// Per-register busy scoreboard for outstanding loads: set on issue, cleared by the
// load writeback port; a same-cycle set wins over the clear.
module arm_rf_scoreboard #(
   parameter  int NUM_REGS = 16,
   parameter  int PC_IDX   = 15,
   localparam int AW       = $clog2(NUM_REGS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                set_en,
   input  logic [AW-1:0]       set_addr,
   input  logic                clr_en,
   input  logic [AW-1:0]       clr_addr,
   output logic [NUM_REGS-1:0] busy_vec
);

   logic [NUM_REGS-1:0] set_vec;
   logic [NUM_REGS-1:0] clr_vec;
   logic [NUM_REGS-1:0] busy_q;

   // The PC slot is never marked busy, so its bit stays 0 from reset on.
   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         if (r != PC_IDX) begin
            set_vec[r] = set_en && (set_addr == AW'(r));
         end
         clr_vec[r] = clr_en && (clr_addr == AW'(r));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q <= '0;
      end else begin
         busy_q <= (busy_q & ~clr_vec) | set_vec;
      end
   end

   assign busy_vec = busy_q;

endmodule

// File: rtl/arm_regfile_mp.sv
// Multi-port ARM register file: async read ports with optional write bypass, two
// synchronous write ports (WP0 wins on collision), PC slot aliased to i_pc.
module arm_regfile_mp
   import arm_core_pkg::*;
#(
   parameter  int DATA_WIDTH = 32,
   parameter  int NUM_REGS   = 16,
   parameter  int NUM_RD     = 3,
   parameter  int PC_IDX     = REG_PC,
   parameter  int BYPASS     = 1,
   localparam int AW         = $clog2(NUM_REGS)
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_RD*AW-1:0]           i_rd_addr,
   output logic [NUM_RD*DATA_WIDTH-1:0]   o_rd_data,
   output logic [NUM_RD-1:0]              o_rd_busy,
   input  logic                           i_wp0_en,
   input  logic [AW-1:0]                  i_wp0_addr,
   input  logic [DATA_WIDTH-1:0]          i_wp0_data,
   input  logic                           i_wp1_en,
   input  logic [AW-1:0]                  i_wp1_addr,
   input  logic [DATA_WIDTH-1:0]          i_wp1_data,
   input  logic                           i_sb_set,
   input  logic [AW-1:0]                  i_sb_addr,
   input  logic [DATA_WIDTH-1:0]          i_pc,
   output logic                           o_pc_wr,
   output logic [DATA_WIDTH-1:0]          o_pc_wr_data,
   output logic [NUM_REGS*DATA_WIDTH-1:0] o_reg_bus,
   output logic [NUM_REGS-1:0]            o_busy_vec
);

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [NUM_REGS-1:0]   busy_vec;
   logic                  wp0_hit_pc;
   logic                  wp1_hit_pc;

   // Non-power-of-2 register counts leave unused address codes; they read as 0.
   function automatic logic in_range(input logic [AW-1:0] a);
      return int'(a) < NUM_REGS;
   endfunction

   // Out-of-range addresses match no slot, so those writes fall away naturally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            regs_q[r] <= '0;
         end
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            if (r != PC_IDX) begin
               if (i_wp0_en && (i_wp0_addr == AW'(r))) begin
                  regs_q[r] <= i_wp0_data;
               end else if (i_wp1_en && (i_wp1_addr == AW'(r))) begin
                  regs_q[r] <= i_wp1_data;
               end
            end
         end
      end
   end

   arm_rf_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .PC_IDX   (PC_IDX)
   ) u_scoreboard (
      .clk      (clk),
      .reset    (reset),
      .set_en   (i_sb_set),
      .set_addr (i_sb_addr),
      .clr_en   (i_wp1_en),
      .clr_addr (i_wp1_addr),
      .busy_vec (busy_vec)
   );

   assign wp0_hit_pc = i_wp0_en && (i_wp0_addr == AW'(PC_IDX));
   assign wp1_hit_pc = i_wp1_en && (i_wp1_addr == AW'(PC_IDX));

   always_comb begin
      o_pc_wr      = wp0_hit_pc || wp1_hit_pc;
      o_pc_wr_data = '0;
      if (wp0_hit_pc) begin
         o_pc_wr_data = i_wp0_data;
      end else if (wp1_hit_pc) begin
         o_pc_wr_data = i_wp1_data;
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [AW-1:0]         addr;
      logic [DATA_WIDTH-1:0] data;

      assign addr = i_rd_addr[k*AW +: AW];

      // PC reads never bypass: the PC write leaves through o_pc_wr instead.
      always_comb begin
         data = '0;
         if (!in_range(addr)) begin
            data = '0;
         end else if (addr == AW'(PC_IDX)) begin
            data = i_pc;
         end else if ((BYPASS != 0) && i_wp0_en && (i_wp0_addr == addr)) begin
            data = i_wp0_data;
         end else if ((BYPASS != 0) && i_wp1_en && (i_wp1_addr == addr)) begin
            data = i_wp1_data;
         end else begin
            data = regs_q[addr];
         end
      end

      assign o_rd_data[k*DATA_WIDTH +: DATA_WIDTH] = data;
      assign o_rd_busy[k] = in_range(addr) ? busy_vec[addr] : 1'b0;
   end

   for (genvar r = 0; r < NUM_REGS; r++) begin : g_bus
      if (r == PC_IDX) begin : g_pc
         assign o_reg_bus[r*DATA_WIDTH +: DATA_WIDTH] = i_pc;
      end else begin : g_gpr
         assign o_reg_bus[r*DATA_WIDTH +: DATA_WIDTH] = regs_q[r];
      end
   end

   assign o_busy_vec = busy_vec;

endmodule

// File: tb/tb_arm_regfile_mp.sv
// Bench for arm_regfile_mp: three builds (bypass, no bypass, 12 regs) driven in lockstep
// and compared every cycle against a behavioural register-file model.
module tb_arm_regfile_mp;

   localparam int NR  [3] = '{16, 16, 12};
   localparam int PCI [3] = '{15, 15, 11};
   localparam int BYP [3] = '{1, 0, 1};

   logic        clk;
   logic        reset;
   logic [11:0] rd_addr;
   logic        wp0_en, wp1_en, sb_set;
   logic [3:0]  wp0_addr, wp1_addr, sb_addr;
   logic [31:0] wp0_data, wp1_data, pc;

   logic [95:0]  rd_data_w    [3];
   logic [2:0]   rd_busy_w    [3];
   logic         pc_wr_w      [3];
   logic [31:0]  pc_wr_data_w [3];
   logic [511:0] reg_bus_w    [2];
   logic [15:0]  busy_vec_w   [2];
   logic [383:0] reg_bus2;
   logic [11:0]  busy_vec2;

   logic [31:0] mem    [3][16];
   logic        busy_m [3][16];

   int n_cmp = 0;
   int n_bad = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   arm_regfile_mp #(.BYPASS(1)) u_byp (
      .clk(clk), .reset(reset), .i_rd_addr(rd_addr),
      .o_rd_data(rd_data_w[0]), .o_rd_busy(rd_busy_w[0]),
      .i_wp0_en(wp0_en), .i_wp0_addr(wp0_addr), .i_wp0_data(wp0_data),
      .i_wp1_en(wp1_en), .i_wp1_addr(wp1_addr), .i_wp1_data(wp1_data),
      .i_sb_set(sb_set), .i_sb_addr(sb_addr), .i_pc(pc),
      .o_pc_wr(pc_wr_w[0]), .o_pc_wr_data(pc_wr_data_w[0]),
      .o_reg_bus(reg_bus_w[0]), .o_busy_vec(busy_vec_w[0]));

   arm_regfile_mp #(.BYPASS(0)) u_nobyp (
      .clk(clk), .reset(reset), .i_rd_addr(rd_addr),
      .o_rd_data(rd_data_w[1]), .o_rd_busy(rd_busy_w[1]),
      .i_wp0_en(wp0_en), .i_wp0_addr(wp0_addr), .i_wp0_data(wp0_data),
      .i_wp1_en(wp1_en), .i_wp1_addr(wp1_addr), .i_wp1_data(wp1_data),
      .i_sb_set(sb_set), .i_sb_addr(sb_addr), .i_pc(pc),
      .o_pc_wr(pc_wr_w[1]), .o_pc_wr_data(pc_wr_data_w[1]),
      .o_reg_bus(reg_bus_w[1]), .o_busy_vec(busy_vec_w[1]));

   arm_regfile_mp #(.NUM_REGS(12), .PC_IDX(11), .BYPASS(1)) u_small (
      .clk(clk), .reset(reset), .i_rd_addr(rd_addr),
      .o_rd_data(rd_data_w[2]), .o_rd_busy(rd_busy_w[2]),
      .i_wp0_en(wp0_en), .i_wp0_addr(wp0_addr), .i_wp0_data(wp0_data),
      .i_wp1_en(wp1_en), .i_wp1_addr(wp1_addr), .i_wp1_data(wp1_data),
      .i_sb_set(sb_set), .i_sb_addr(sb_addr), .i_pc(pc),
      .o_pc_wr(pc_wr_w[2]), .o_pc_wr_data(pc_wr_data_w[2]),
      .o_reg_bus(reg_bus2), .o_busy_vec(busy_vec2));

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_read(input int d, input logic [3:0] a);
      int ai = int'(a);
      if (ai >= NR[d]) return 32'h0;
      if (ai == PCI[d]) return pc;
      if (BYP[d] != 0 && wp0_en && wp0_addr == a) return wp0_data;
      if (BYP[d] != 0 && wp1_en && wp1_addr == a) return wp1_data;
      return mem[d][ai];
   endfunction

   function automatic void model_reset();
      for (int d = 0; d < 3; d++)
         for (int r = 0; r < 16; r++) begin
            mem[d][r]    = 32'h0;
            busy_m[d][r] = 1'b0;
         end
   endfunction

   function automatic void model_update();
      for (int d = 0; d < 3; d++) begin
         int a0 = int'(wp0_addr);
         int a1 = int'(wp1_addr);
         int as = int'(sb_addr);
         if (wp1_en && a1 < NR[d] && a1 != PCI[d]) mem[d][a1] = wp1_data;
         if (wp0_en && a0 < NR[d] && a0 != PCI[d]) mem[d][a0] = wp0_data;
         if (wp1_en && a1 < NR[d]) busy_m[d][a1] = 1'b0;
         if (sb_set && as < NR[d] && as != PCI[d]) busy_m[d][as] = 1'b1;
      end
   endfunction

   task automatic check_all();
      for (int d = 0; d < 3; d++) begin
         logic        e_pcw  = 1'b0;
         logic [31:0] e_pcd  = 32'h0;
         logic [511:0] e_bus = '0;
         logic [15:0] e_bv   = '0;
         for (int k = 0; k < 3; k++) begin
            logic [3:0] a = rd_addr[k*4 +: 4];
            logic       eb = (int'(a) < NR[d]) ? busy_m[d][int'(a)] : 1'b0;
            chk($sformatf("d%0d_rd%0d_data", d, k), rd_data_w[d][k*32 +: 32], exp_read(d, a));
            chk($sformatf("d%0d_rd%0d_busy", d, k), rd_busy_w[d][k], eb);
         end
         if (wp0_en && int'(wp0_addr) == PCI[d]) begin
            e_pcw = 1'b1;
            e_pcd = wp0_data;
         end else if (wp1_en && int'(wp1_addr) == PCI[d]) begin
            e_pcw = 1'b1;
            e_pcd = wp1_data;
         end
         chk($sformatf("d%0d_pc_wr", d), pc_wr_w[d], e_pcw);
         chk($sformatf("d%0d_pc_wr_data", d), pc_wr_data_w[d], e_pcd);
         for (int r = 0; r < NR[d]; r++) begin
            e_bus[r*32 +: 32] = (r == PCI[d]) ? pc : mem[d][r];
            e_bv[r] = busy_m[d][r];
         end
         if (d == 2) begin
            chk("d2_reg_bus", reg_bus2, e_bus);
            chk("d2_busy_vec", busy_vec2, e_bv);
         end else begin
            chk($sformatf("d%0d_reg_bus", d), reg_bus_w[d], e_bus);
            chk($sformatf("d%0d_busy_vec", d), busy_vec_w[d], e_bv);
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      check_all();
      if (reset) model_reset();
      else model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wp0_en = 1'b0;
      wp1_en = 1'b0;
      sb_set = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      rd_addr = 12'h0;
      wp0_addr = 4'h0; wp0_data = 32'h0;
      wp1_addr = 4'h0; wp1_data = 32'h0;
      sb_addr = 4'h0;  pc = 32'h0;
      idle();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      rd_addr = {4'd2, 4'd1, 4'd0};
      #2;
      chk("t1_r1_zero", rd_data_w[0][63:32], 32'h0);
      chk("t1_busy_vec", busy_vec_w[0], 16'h0);
      step();

      wp0_en = 1'b1; wp0_addr = 4'd1; wp0_data = 32'h11;
      wp1_en = 1'b1; wp1_addr = 4'd2; wp1_data = 32'h22;
      step();
      idle();
      #2;
      chk("t2_r1", rd_data_w[0][63:32], 32'h11);
      chk("t2_r2", rd_data_w[1][95:64], 32'h22);
      step();

      rd_addr = {4'd2, 4'd1, 4'd3};
      wp0_en = 1'b1; wp0_addr = 4'd3; wp0_data = 32'hAA;
      wp1_en = 1'b1; wp1_addr = 4'd3; wp1_data = 32'hBB;
      #2;
      chk("t3_bypass", rd_data_w[0][31:0], 32'hAA);
      chk("t3_nobypass_old", rd_data_w[1][31:0], 32'h0);
      step();
      idle();
      #2;
      chk("t3_r3", rd_data_w[1][31:0], 32'hAA);
      step();

      pc = 32'h108;
      rd_addr = {4'd2, 4'd1, 4'd15};
      #2;
      chk("t4_pc_read", rd_data_w[0][31:0], 32'h108);
      wp0_en = 1'b1; wp0_addr = 4'd15; wp0_data = 32'h200;
      #2;
      chk("t4_pc_wr", pc_wr_w[0], 1'b1);
      chk("t4_pc_wr_data", pc_wr_data_w[0], 32'h200);
      chk("t4_pc_read_byp", rd_data_w[0][31:0], 32'h108);
      step();
      idle();
      #2;
      chk("t4_pc_after", rd_data_w[0][31:0], 32'h108);
      chk("t4_pc_wr_idle", pc_wr_w[0], 1'b0);
      step();

      rd_addr = {4'd2, 4'd1, 4'd4};
      sb_set = 1'b1; sb_addr = 4'd4;
      step();
      idle();
      #2;
      chk("t5_busy_set", rd_busy_w[0][0], 1'b1);
      sb_set = 1'b1; sb_addr = 4'd4;
      wp1_en = 1'b1; wp1_addr = 4'd4; wp1_data = 32'h44;
      step();
      idle();
      #2;
      chk("t5_set_wins", rd_busy_w[0][0], 1'b1);
      wp1_en = 1'b1; wp1_addr = 4'd4; wp1_data = 32'h45;
      step();
      idle();
      #2;
      chk("t5_cleared", rd_busy_w[0][0], 1'b0);
      sb_set = 1'b1; sb_addr = 4'd4;
      step();
      idle();
      wp0_en = 1'b1; wp0_addr = 4'd4; wp0_data = 32'h46;
      step();
      idle();
      #2;
      chk("t5_wp0_keeps_busy", rd_busy_w[0][0], 1'b1);
      step();

      rd_addr = {4'd2, 4'd1, 4'd5};
      wp0_en = 1'b1; wp0_addr = 4'd5; wp0_data = 32'h55;
      #2;
      chk("t6_nobyp_same", rd_data_w[1][31:0], 32'h0);
      step();
      idle();
      #2;
      chk("t6_nobyp_next", rd_data_w[1][31:0], 32'h55);
      step();

      wp0_en = 1'b1; wp0_addr = 4'd6; wp0_data = 32'h66;
      wp1_en = 1'b1; wp1_addr = 4'd7; wp1_data = 32'h77;
      sb_set = 1'b1; sb_addr = 4'd8;
      @(negedge clk);
      #1;
      reset = 1'b1;
      model_reset();
      #1;
      chk("rst_async_r1", reg_bus_w[0][63:32], 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      idle();
      rd_addr = {4'd8, 4'd7, 4'd6};
      #2;
      chk("rst_r6_lost", rd_data_w[0][31:0], 32'h0);
      chk("rst_r7_lost", rd_data_w[0][63:32], 32'h0);
      chk("rst_busy8_lost", rd_busy_w[0][2], 1'b0);
      step();

      for (int i = 0; i < 400; i++) begin
         rd_addr  = 12'($urandom);
         wp0_en   = 1'($urandom);
         wp0_addr = 4'($urandom);
         wp0_data = $urandom;
         wp1_en   = 1'($urandom);
         wp1_addr = ($urandom_range(0, 3) == 0) ? wp0_addr : 4'($urandom);
         wp1_data = $urandom;
         sb_set   = ($urandom_range(0, 2) == 0);
         sb_addr  = 4'($urandom);
         pc       = $urandom;
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
